apb_requester: RTL and testbench
================================

// Module: apb_requester
// PURPOSE
//   APB requester (master end): converts single command transactions into APB SETUP/ACCESS
//   transfers and returns one response per command. Drives the same PCLK/PADDR/PSEL/PENABLE/
//   PREADY/PSLVERR interface the responder properties check; the responder side sits downstream.
//   Includes a wait-state timeout so a hung responder cannot stall the command stream.
// PARAMETERS
//   ADDR_WIDTH      8    PADDR / cmd_addr width
//   DATA_WIDTH      32   PWDATA / PRDATA / cmd_wdata / rsp_rdata width
//   TIMEOUT_CYCLES  16   max ACCESS cycles with PREADY=0 before abort; 0 disables timeout
// PORTS
//   PCLK         in   1           clock, all logic on posedge
//   PRESET       in   1           reset, synchronous, active-high
//   cmd_valid    in   1           command offered
//   cmd_ready    out  1           command accepted when cmd_valid && cmd_ready
//   cmd_write    in   1           1 = write, 0 = read
//   cmd_addr     in   ADDR_WIDTH  transfer address
//   cmd_wdata    in   DATA_WIDTH  write data (ignored for reads)
//   rsp_valid    out  1           response available
//   rsp_ready    in   1           response consumed when rsp_valid && rsp_ready
//   rsp_rdata    out  DATA_WIDTH  read data; 0 for writes, errors-by-timeout
//   rsp_error    out  1           PSLVERR sampled, or timeout
//   rsp_timeout  out  1           transfer aborted by timeout
//   PADDR        out  ADDR_WIDTH  APB address
//   PSEL         out  1           APB select
//   PENABLE      out  1           APB enable
//   PWRITE       out  1           APB direction
//   PWDATA       out  DATA_WIDTH  APB write data
//   PRDATA       in   DATA_WIDTH  APB read data
//   PREADY       in   1           APB ready / wait-state
//   PSLVERR      in   1           APB error, valid only with PSEL && PENABLE && PREADY
// BEHAVIOUR
//   - Reset (PRESET=1 at posedge): state IDLE; all outputs 0 (cmd_ready=0 during reset, 1 first
//     cycle after); timeout counter 0. Reset mid-transfer: PSEL/PENABLE low after that edge, no
//     response produced, command dropped.
//   - All outputs registered or decoded from state register only; no combinational in->out paths.
//   - FSM IDLE -> SETUP -> ACCESS -> RESP -> IDLE:
//     IDLE:   cmd_ready=1, PSEL=0, PENABLE=0. On cmd_valid: latch write/addr/wdata onto
//             PWRITE/PADDR/PWDATA, clear counter, -> SETUP.
//     SETUP:  PSEL=1, PENABLE=0, exactly one cycle, -> ACCESS.
//     ACCESS: PSEL=1, PENABLE=1. PREADY=1: capture PRDATA (reads; writes capture 0) and
//             PSLVERR into rsp_*, rsp_timeout=0, -> RESP. PREADY=0: counter++, stay; if
//             TIMEOUT_CYCLES!=0 and this is the TIMEOUT_CYCLES-th stalled ACCESS cycle, -> RESP
//             with rsp_rdata=0, rsp_error=1, rsp_timeout=1.
//     RESP:   rsp_valid=1, PSEL=PENABLE=0, cmd_ready=0; rsp_* held stable until rsp_ready;
//             then -> IDLE.
//   - PADDR/PWRITE/PWDATA stable from SETUP through last ACCESS cycle; hold last value otherwise.
//   - Latency: accept at cycle N -> SETUP N+1, ACCESS N+2, rsp_valid N+3 with zero wait states.
//     Best-case throughput one transfer per 4 cycles (rsp_ready tied high).
//   - PREADY=1 on the cycle the timeout would fire: normal completion wins.
//   - PSLVERR ignored unless PREADY=1 in ACCESS. PREADY/PSLVERR ignored outside ACCESS.
//   - Counter width $clog2(TIMEOUT_CYCLES+1), saturates; never wraps.
// TESTING
//   1. Write 0xDEADBEEF to addr 0x00, PREADY=1 -> PSEL at N+1, PENABLE at N+2, rsp_valid at N+3,
//      rsp_error=0, rsp_rdata=0.
//   2. Read addr 0x04, PREADY low 3 cycles, PRDATA=0x12345678 -> 4 ACCESS cycles, PADDR stable,
//      rsp_rdata=0x12345678, rsp_error=0.
//   3. Read addr 0x01, PREADY=1 with PSLVERR=1 -> rsp_error=1, rsp_timeout=0.
//   4. TIMEOUT_CYCLES=16, PREADY held 0 -> PSEL drops after 16th ACCESS cycle, rsp_error=1,
//      rsp_timeout=1, rsp_rdata=0; PREADY=1 on 16th cycle instead -> normal completion.
//   5. rsp_ready low 5 cycles, cmd_valid held -> rsp_* stable, cmd_ready=0, no new PSEL until
//      response taken.
//   6. PRESET=1 during ACCESS -> PSEL=PENABLE=0 after edge, no rsp_valid, cmd_ready=1 first
//      cycle after reset released.

Source files
------------

// File: rtl/apb_requester.sv
// rtl/apb_requester.sv - APB requester: one command in, one SETUP/ACCESS transfer out, one response back.
// Wait-state timeout aborts a transfer whose responder never raises PREADY.
module apb_requester #(
    parameter int ADDR_WIDTH     = 8,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                  PCLK,
    input  logic                  PRESET,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [DATA_WIDTH-1:0] cmd_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_error,
    output logic                  rsp_timeout,
    output logic [ADDR_WIDTH-1:0] PADDR,
    output logic                  PSEL,
    output logic                  PENABLE,
    output logic                  PWRITE,
    output logic [DATA_WIDTH-1:0] PWDATA,
    input  logic [DATA_WIDTH-1:0] PRDATA,
    input  logic                  PREADY,
    input  logic                  PSLVERR
);

    // A zero timeout still gets a 1-bit counter so the declaration stays legal.
    localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CW-1:0] CNT_MAX  = '1;
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_LAST = (TIMEOUT_CYCLES > 0) ? CW'(TIMEOUT_CYCLES - 1) : '0;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS,
        RESP
    } state_t;

    state_t          state;
    state_t          next_state;
    logic [CW-1:0]   cnt;
    logic            ready_q;
    logic            accept;
    logic            timeout_hit;

    assign accept      = (state == IDLE) && ready_q && cmd_valid;
    // Fires on the stalled ACCESS cycle that would be the TIMEOUT_CYCLES-th one.
    assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt == CNT_LAST) && !PREADY;

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (accept) next_state = SETUP;
            SETUP:   next_state = ACCESS;
            ACCESS:  if (PREADY || timeout_hit) next_state = RESP;
            RESP:    if (rsp_ready) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state       <= IDLE;
            ready_q     <= 1'b0;
            cnt         <= '0;
            PADDR       <= '0;
            PWRITE      <= 1'b0;
            PWDATA      <= '0;
            rsp_rdata   <= '0;
            rsp_error   <= 1'b0;
            rsp_timeout <= 1'b0;
        end else begin
            state   <= next_state;
            ready_q <= (next_state == IDLE);
            if (accept) begin
                PADDR  <= cmd_addr;
                PWRITE <= cmd_write;
                PWDATA <= cmd_wdata;
                cnt    <= '0;
            end
            if (state == ACCESS) begin
                if (PREADY) begin
                    rsp_rdata   <= PWRITE ? '0 : PRDATA;
                    rsp_error   <= PSLVERR;
                    rsp_timeout <= 1'b0;
                end else begin
                    if (cnt != CNT_MAX) cnt <= cnt + CNT_ONE;
                    if (timeout_hit) begin
                        rsp_rdata   <= '0;
                        rsp_error   <= 1'b1;
                        rsp_timeout <= 1'b1;
                    end
                end
            end
        end
    end

    assign cmd_ready = ready_q;
    assign PSEL      = (state == SETUP) || (state == ACCESS);
    assign PENABLE   = (state == ACCESS);
    assign rsp_valid = (state == RESP);

endmodule

// File: tb/tb_apb_requester.sv
// tb/tb_apb_requester.sv - randomized bench for apb_requester with a transaction-level response model.
module tb_apb_requester;
    localparam int AW = 8;
    localparam int DW = 32;
    localparam int TO = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          cmd_valid, cmd_ready, cmd_write;
    logic [AW-1:0] cmd_addr;
    logic [DW-1:0] cmd_wdata;
    logic          rsp_valid, rsp_ready;
    logic [DW-1:0] rsp_rdata;
    logic          rsp_error, rsp_timeout;
    logic [AW-1:0] paddr;
    logic          psel, penable, pwrite;
    logic [DW-1:0] pwdata, prdata;
    logic          pready, pslverr;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    apb_requester #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)) dut (
        .PCLK(clk), .PRESET(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_error(rsp_error), .rsp_timeout(rsp_timeout),
        .PADDR(paddr), .PSEL(psel), .PENABLE(penable), .PWRITE(pwrite),
        .PWDATA(pwdata), .PRDATA(prdata), .PREADY(pready), .PSLVERR(pslverr)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // The responder stalls for 'waits' ACCESS cycles, then answers with err/rdata.
    task automatic do_txn(input logic wr, input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                          input int waits, input logic err, input logic [DW-1:0] rdata,
                          input int rdelay);
        int       n;
        int       k;
        bit       timed_out;
        int       exp_acc;
        logic [DW-1:0] exp_rd;
        logic     exp_err;
        timed_out = (TO != 0) && (waits >= TO);
        exp_acc   = timed_out ? TO : waits + 1;
        exp_rd    = (timed_out || wr) ? '0 : rdata;
        exp_err   = timed_out ? 1'b1 : err;

        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_write = wr;
        cmd_addr  = addr;
        cmd_wdata = wdata;
        n = 0;
        while (cmd_ready !== 1'b1 && n < 10) begin
            @(negedge clk);
            n++;
        end
        check("cmd_ready_wait", 64'(n < 10), 64'(1));
        @(negedge clk);
        cmd_valid = 1'b0;
        cmd_addr  = AW'($urandom);
        cmd_wdata = $urandom;
        cmd_write = 1'($urandom);
        check("setup_phase", 64'({psel, penable}), 64'(2'b10));
        check("setup_paddr", 64'(paddr), 64'(addr));
        check("setup_pwrite", 64'(pwrite), 64'(wr));
        if (wr) check("setup_pwdata", 64'(pwdata), 64'(wdata));
        pready  = 1'($urandom);
        pslverr = 1'($urandom);
        prdata  = $urandom;
        @(negedge clk);
        k = 0;
        while (psel && penable && k < 40) begin
            check("access_addr", 64'({pwrite, paddr}), 64'({wr, addr}));
            pready  = (k == waits);
            pslverr = (k == waits) ? err : 1'($urandom);
            prdata  = (k == waits) ? rdata : DW'($urandom);
            k++;
            @(negedge clk);
        end
        check("access_cycles", 64'(k), 64'(exp_acc));
        pready  = 1'($urandom);
        pslverr = 1'($urandom);
        prdata  = $urandom;
        check("rsp_valid", 64'(rsp_valid), 64'(1));
        check("rsp_psel_low", 64'({psel, penable, cmd_ready}), 64'(0));
        check("rsp_rdata", 64'(rsp_rdata), 64'(exp_rd));
        check("rsp_flags", 64'({rsp_error, rsp_timeout}), 64'({exp_err, timed_out}));
        for (int i = 0; i < rdelay; i++) begin
            rsp_ready = 1'b0;
            cmd_valid = 1'b1;
            cmd_addr  = AW'($urandom);
            @(negedge clk);
            check("hold_rsp", 64'({rsp_valid, rsp_error, rsp_timeout, rsp_rdata}),
                  64'({1'b1, exp_err, timed_out, exp_rd}));
            check("hold_no_cmd", 64'({cmd_ready, psel}), 64'(0));
        end
        rsp_ready = 1'b1;
        cmd_valid = 1'b0;
        @(negedge clk);
        rsp_ready = 1'b0;
        check("rsp_taken", 64'({rsp_valid, cmd_ready, psel}), 64'(3'b010));
    endtask

    initial begin
        int n;
        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_addr  = '0;
        cmd_wdata = '0;
        rsp_ready = 1'b0;
        prdata    = '0;
        pready    = 1'b0;
        pslverr   = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_ctrl", 64'({cmd_ready, rsp_valid, psel, penable, pwrite, rsp_error, rsp_timeout}), 64'(0));
        check("reset_data", 64'({paddr, pwdata}), 64'(0));
        check("reset_rdata", 64'(rsp_rdata), 64'(0));
        rst = 1'b0;
        @(negedge clk);
        check("ready_after_reset", 64'(cmd_ready), 64'(1));

        do_txn(1'b1, 8'h00, 32'hDEADBEEF, 0, 1'b0, 32'h0, 0);
        do_txn(1'b0, 8'h04, 32'h0, 3, 1'b0, 32'h12345678, 0);
        do_txn(1'b0, 8'h01, 32'h0, 0, 1'b1, 32'hA5A5A5A5, 1);
        do_txn(1'b0, 8'h10, 32'h0, 100, 1'b0, 32'h11111111, 0);
        do_txn(1'b0, 8'h11, 32'h0, 15, 1'b0, 32'h22222222, 0);
        do_txn(1'b1, 8'h12, 32'hCAFEF00D, 16, 1'b0, 32'h0, 2);
        do_txn(1'b1, 8'h20, 32'h01020304, 1, 1'b0, 32'h0, 5);

        for (int t = 0; t < 40; t++)
            do_txn(1'($urandom), AW'($urandom), $urandom, int'($urandom_range(0, 20)),
                   1'($urandom), $urandom, int'($urandom_range(0, 3)));

        // Reset while the responder is stalling in ACCESS.
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_write = 1'b0;
        cmd_addr  = 8'h33;
        n = 0;
        while (cmd_ready !== 1'b1 && n < 10) begin
            @(negedge clk);
            n++;
        end
        check("rst_cmd_wait", 64'(n < 10), 64'(1));
        @(negedge clk);
        cmd_valid = 1'b0;
        pready    = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_in_access", 64'({psel, penable}), 64'(2'b11));
        rst = 1'b1;
        @(negedge clk);
        check("rst_mid_xfer", 64'({psel, penable, rsp_valid, cmd_ready}), 64'(0));
        rst = 1'b0;
        @(negedge clk);
        check("rst_release", 64'({cmd_ready, rsp_valid, psel}), 64'(3'b100));
        @(negedge clk);
        check("rst_no_rsp", 64'({rsp_valid, psel}), 64'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
